// File: rtl/spi_memory_if.sv
// spi_memory_if -- pin-level bundle for the SPI memory block.
//   sclk_pin, cs_pin, mosi_pin, faultinjector_pin : raw inputs to the block
//   miso_pin                                      : registered serial data out
//   leds[7:0]                                     : {4'b0, miso_en, addrlatch_en, dm_we, sr_we}
//   state[3:0]                                    : current FSM state encoding
// The master modport drives the raw pins (board / testbench side); the slave
// modport is the spi_memory side.
interface spi_memory_if;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       faultinjector_pin;
  logic       miso_pin;
  logic [7:0] leds;
  logic [3:0] state;

  modport master (
    output sclk_pin, cs_pin, mosi_pin, faultinjector_pin,
    input  miso_pin, leds, state
  );

  modport slave (
    input  sclk_pin, cs_pin, mosi_pin, faultinjector_pin,
    output miso_pin, leds, state
  );
endinterface

// File: rtl/spi_memory.sv
// spi_memory -- SPI slave fronting a 128 x 8 memory.
//   clk    : system clock, all state on its rising edge
//   reset  : asynchronous, active-high
//   bus    : spi_memory_if.slave (raw SPI pins, miso, leds, state)
// Raw pins are synchronised and debounced (3 stable cycles) before use.
// Byte 1 = {rw, addr[6:0]} MSB first (rw=1 read); a write carries one data
// byte, a read returns mem[addr] on miso, changed on sclk falling edges.
// Optional build macro FAULT_INJECT_EN: when defined and the conditioned
// faultinjector_pin is high, the latched address has bit 2 forced to 1.
module spi_memory (
  input  logic        clk,
  input  logic        reset,
  spi_memory_if.slave bus
);
  localparam int IDX_SCLK = 0;
  localparam int IDX_CS   = 1;
  localparam int IDX_MOSI = 2;
  localparam int IDX_FI   = 3;
  // Idle level of each conditioned input: chip select idles high.
  localparam logic [3:0] IDLE_VAL = 4'b0010;

  typedef enum logic [2:0] {
    GET    = 3'd0,
    GOT    = 3'd1,
    READ1  = 3'd2,
    READ2  = 3'd3,
    READ3  = 3'd4,
    WRITE1 = 3'd5,
    WRITE2 = 3'd6,
    DONE   = 3'd7
  } state_t;

  // ---------------------------------------------------------------- inputs
  logic [3:0]      raw_in, sync1_q, sync2_q, cond_q;
  logic [3:0][1:0] db_cnt_q;
  logic            sclk_rise, sclk_fall;

  assign raw_in = {bus.faultinjector_pin, bus.mosi_pin, bus.cs_pin, bus.sclk_pin};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= IDLE_VAL;
      sync2_q   <= IDLE_VAL;
      cond_q    <= IDLE_VAL;
      db_cnt_q  <= '0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == cond_q[i]) begin
          db_cnt_q[i] <= 2'd0;
        end else if (db_cnt_q[i] == 2'd2) begin
          // Third consecutive differing cycle: accept the new level. The
          // edge pulse is registered alongside, so it coincides with it.
          cond_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= 2'd0;
          if (i == IDX_SCLK) begin
            sclk_rise <= sync2_q[i];
            sclk_fall <= ~sync2_q[i];
          end
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 2'd1;
        end
      end
    end
  end

  logic cs_high, mosi;
  assign cs_high = cond_q[IDX_CS];
  assign mosi    = cond_q[IDX_MOSI];

  // ------------------------------------------------------------ datapath
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] sr_q;
  logic [6:0] dm_addr, latch_addr;
  logic [7:0] mem [128];
  logic [7:0] mem_rdata;
  logic       miso_q;
  logic       sr_we, dm_we, addrlatch_en, miso_en;
  logic       counting, byte_done;

  assign mem_rdata = mem[dm_addr];
  assign counting  = state_q inside {GET, READ3, WRITE1};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

`ifdef FAULT_INJECT_EN
  assign latch_addr = cond_q[IDX_FI] ? {sr_q[6:3], 1'b1, sr_q[1:0]} : sr_q[6:0];
`else
  logic unused_fault;
  assign latch_addr   = sr_q[6:0];
  assign unused_fault = cond_q[IDX_FI];
`endif

  // NOTE: the memory array has no reset; its contents survive reset and
  // a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= sr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= GET;
      bit_cnt_q <= 3'd0;
      sr_q      <= 8'h00;
      dm_addr   <= 7'd0;
      miso_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // The 3-bit counter wraps to 0 on the 8th pulse, ready for the next byte.
      if (cs_high || !counting) bit_cnt_q <= 3'd0;
      else if (sclk_rise)       bit_cnt_q <= bit_cnt_q + 3'd1;
      if (sr_we)                sr_q <= mem_rdata;
      else if (sclk_rise)       sr_q <= {sr_q[6:0], mosi};
      if (addrlatch_en)         dm_addr <= latch_addr;
      if (sclk_fall && miso_en) miso_q <= sr_q[7];
    end
  end

  // ----------------------------------------------------------------- FSM
  // NOTE: every signal driven here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d      = state_q;
    sr_we        = 1'b0;
    dm_we        = 1'b0;
    addrlatch_en = 1'b0;
    miso_en      = 1'b0;
    unique case (state_q)
      GET:    if (byte_done) state_d = GOT;
      GOT: begin
        addrlatch_en = 1'b1;
        state_d      = sr_q[7] ? READ1 : WRITE1;
      end
      READ1:  state_d = READ2;        // let dm_addr settle before the load
      READ2: begin
        sr_we   = 1'b1;
        state_d = READ3;
      end
      READ3: begin
        miso_en = 1'b1;
        if (byte_done) state_d = DONE;
      end
      WRITE1: if (byte_done) state_d = WRITE2;
      WRITE2: begin
        dm_we   = 1'b1;
        state_d = DONE;
      end
      DONE:   state_d = DONE;
      default: state_d = GET;
    endcase
    // Deselect aborts from any state.
    if (cs_high) state_d = GET;
  end

  assign bus.miso_pin = miso_q;
  assign bus.leds     = {4'b0000, miso_en, addrlatch_en, dm_we, sr_we};
  assign bus.state    = {1'b0, state_q};
endmodule

// File: tb/tb_spi_memory.sv
// tb_spi_memory -- self-checking bench for spi_memory. A byte-array model of
// the memory predicts every read; directed cases cover write/read state
// sequences, debounce, fault-inject addressing, abort and mid-write reset.
module tb_spi_memory;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_memory_if bus ();

  spi_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef FAULT_INJECT_EN
  localparam bit FAULT_ON = 1'b1;
`else
  localparam bit FAULT_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain byte array plus written-flags.
  logic [7:0] model_mem [128];
  bit         model_valid [128];

  // Monitor: state-change trace and event counters, sampled on falling clk.
  logic [3:0] trace [$];
  logic [3:0] last_state = 4'd0;
  int we_cnt = 0, rise_cnt = 0, fall_cnt = 0;

  always @(negedge clk) begin
    if (bus.state != last_state) begin
      trace.push_back(bus.state);
      last_state = bus.state;
    end
    if (bus.leds[1])    we_cnt++;
    if (dut.sclk_rise)  rise_cnt++;
    if (dut.sclk_fall)  fall_cnt++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare trace entries from index start against n nibbles packed in exp.
  task automatic check_trace(input string tag, input int start, input logic [31:0] exp, input int n);
    logic [31:0] obs;
    check({tag, "_len"}, trace.size() - start, n);
    for (int k = 0; k < n; k++) begin
      obs = (start + k < trace.size()) ? {28'd0, trace[start + k]} : 32'hFFFF;
      check(tag, obs, {28'd0, exp[4 * (n - 1 - k) +: 4]});
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    bus.mosi_pin = b;
    repeat (8) @(negedge clk);
    r = bus.miso_pin;
    bus.sclk_pin = 1'b1;
    repeat (8) @(negedge clk);
    bus.sclk_pin = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_start();
    bus.cs_pin = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (8) @(negedge clk);
    bus.cs_pin = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  function automatic logic [6:0] eff_addr(input logic [6:0] a, input bit fi);
    return (fi && FAULT_ON) ? (a | 7'h04) : a;
  endfunction

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    cs_start();
    spi_byte({1'b0, a}, dummy);
    spi_byte(d, dummy);
    cs_end();
    model_mem[eff_addr(a, bus.faultinjector_pin)]   = d;
    model_valid[eff_addr(a, bus.faultinjector_pin)] = 1'b1;
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    cs_start();
    spi_byte({1'b1, a}, dummy);
    spi_byte(8'h00, d);
    cs_end();
  endtask

  initial begin
    logic [7:0] rd;
    logic [6:0] a;
    logic [7:0] d;
    logic       r;
    int         t0, w0, r0, f0;

    reset = 1'b1;
    bus.sclk_pin = 1'b0;
    bus.cs_pin = 1'b1;
    bus.mosi_pin = 1'b0;
    bus.faultinjector_pin = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_leds", bus.leds, 0);
    check("rst_miso", bus.miso_pin, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Directed write 0x05 <- 0xA5.
    t0 = trace.size(); w0 = we_cnt;
    check("wr_start_state", bus.state, 0);
    spi_write(7'h05, 8'hA5);
    check_trace("wr_trace", t0, 32'h15670, 5);
    check("wr_we_pulses", we_cnt - w0, 1);

    // Directed read of 0x05; bits sampled before each sclk rise.
    t0 = trace.size();
    spi_read(7'h05, rd);
    check("rd_data", rd, 8'hA5);
    check_trace("rd_trace", t0, 32'h123470, 6);

    // Debounce: 2-clk glitch inside a transaction must not shift or count.
    r0 = rise_cnt; f0 = fall_cnt;
    cs_start();
    bus.sclk_pin = 1'b1;
    repeat (2) @(negedge clk);
    bus.sclk_pin = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_rise", rise_cnt - r0, 0);
    check("glitch_fall", fall_cnt - f0, 0);
    check("glitch_state", bus.state, 0);
    spi_byte(8'h0A, rd);
    spi_byte(8'h5A, rd);
    cs_end();
    model_mem[10] = 8'h5A; model_valid[10] = 1'b1;
    spi_read(7'h0A, rd);
    check("glitch_wr_data", rd, model_mem[10]);
    // A 10-clk pulse while deselected gives exactly one edge of each kind.
    r0 = rise_cnt; f0 = fall_cnt;
    bus.sclk_pin = 1'b1;
    repeat (10) @(negedge clk);
    bus.sclk_pin = 1'b0;
    repeat (10) @(negedge clk);
    check("pulse_rise", rise_cnt - r0, 1);
    check("pulse_fall", fall_cnt - f0, 1);

    // Fault-inject pin: address bit 2 forced only when the macro is built in.
    spi_write(7'h01, 8'h11);
    spi_write(7'h05, 8'h22);
    bus.faultinjector_pin = 1'b1;
    repeat (10) @(negedge clk);
    spi_write(7'h01, 8'h3C);
    bus.faultinjector_pin = 1'b0;
    repeat (10) @(negedge clk);
    spi_read(7'h01, rd);
    check("fault_mem1", rd, model_mem[1]);
    spi_read(7'h05, rd);
    check("fault_mem5", rd, model_mem[5]);
    check("fault_mem1_abs", model_mem[1], FAULT_ON ? 8'h11 : 8'h3C);

    // Randomised traffic against the model.
    for (int n = 0; n < 24; n++) begin
      a = 7'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        spi_write(a, d);
      end else begin
        spi_read(a, rd);
        if (model_valid[a]) check("rand_read", rd, model_mem[a]);
      end
    end

    // Abort: CS raised after 4 bits of the data byte.
    spi_write(7'h20, 8'h77);
    w0 = we_cnt;
    cs_start();
    spi_byte(8'h20, rd);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    check("abort_pre_state", bus.state, 5);
    bus.cs_pin = 1'b1;
    for (int k = 0; k < 12 && bus.state != 4'd0; k++) @(negedge clk);
    check("abort_state", bus.state, 0);
    repeat (10) @(negedge clk);
    check("abort_we", we_cnt - w0, 0);
    spi_read(7'h20, rd);
    check("abort_mem", rd, model_mem[32]);

    // Reset in WRITE1: miso left high by a read ending in a 1.
    spi_write(7'h09, 8'h33);
    spi_read(7'h09, rd);
    check("pre_rst_read", rd, 8'h33);
    check("pre_rst_miso", bus.miso_pin, 1);
    w0 = we_cnt;
    cs_start();
    spi_byte(8'h09, rd);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    check("rst_pre_state", bus.state, 5);
    reset = 1'b1;
    #1;
    check("midrst_state", bus.state, 0);
    check("midrst_miso", bus.miso_pin, 0);
    check("midrst_addr", dut.dm_addr, 0);
    bus.cs_pin = 1'b1;
    bus.mosi_pin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_we", we_cnt - w0, 0);
    spi_read(7'h09, rd);
    check("midrst_mem", rd, model_mem[9]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
